// File: rtl/isp_param_fetch.sv
// ISP polygon parameter fetch: reads the 3 header words and 3x3 vertex words of one polygon
// from VRAM and presents them to the rasteriser until acknowledged.
module isp_param_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic        render_poly,
    input  logic [23:0] poly_addr,
    input  logic [2:0]  skip,
    input  logic [31:0] PARAM_BASE,
    output logic        isp_vram_rd,
    output logic [23:0] isp_vram_addr,
    input  logic [31:0] isp_vram_din,
    output logic [31:0] isp_inst,
    output logic [31:0] tsp_inst,
    output logic [31:0] tcw,
    output logic [31:0] vert_a_x,
    output logic [31:0] vert_a_y,
    output logic [31:0] vert_a_z,
    output logic [31:0] vert_b_x,
    output logic [31:0] vert_b_y,
    output logic [31:0] vert_b_z,
    output logic [31:0] vert_c_x,
    output logic [31:0] vert_c_y,
    output logic [31:0] vert_c_z,
    output logic        poly_valid,
    input  logic        poly_ack,
    output logic        poly_drawn,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLast,
        StValid,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  skip_q, skip_d;
    logic [23:0] addr_q, addr_d;
    logic        cap_en_q;
    logic [3:0]  cap_idx_q;
    logic [31:0] words_q [12];
    logic        jump;

    // Only the low 24 bits of the parameter base address VRAM.
    logic unused_base;
    assign unused_base = ^PARAM_BASE[31:24];

    // After the last component of vertex a or b, step over the skip words as well.
    assign jump = (idx_q == 4'd5) || (idx_q == 4'd8);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (render_poly) begin
                    state_d = StFetch;
                    idx_d   = 4'd0;
                    skip_d  = skip;
                    addr_d  = PARAM_BASE[23:0] + poly_addr;
                end
            end
            StFetch: begin
                if (idx_q == 4'd11) begin
                    state_d = StLast;
                end else begin
                    idx_d  = idx_q + 4'd1;
                    addr_d = addr_q + 24'd4 + (jump ? {19'd0, skip_q, 2'b00} : 24'd0);
                end
            end
            StLast:  state_d = StValid;
            StValid: begin
                if (poly_ack) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= 4'd0;
            skip_q    <= 3'd0;
            addr_q    <= 24'd0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= 4'd0;
            for (int i = 0; i < 12; i++) begin
                words_q[i] <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            skip_q    <= skip_d;
            addr_q    <= addr_d;
            // Read data arrives one cycle after the strobe; capture it then.
            cap_en_q  <= isp_vram_rd;
            cap_idx_q <= idx_q;
            if (cap_en_q) begin
                words_q[cap_idx_q] <= isp_vram_din;
            end
        end
    end

    assign isp_vram_rd   = (state_q == StFetch);
    assign isp_vram_addr = addr_q;
    assign poly_valid    = (state_q == StValid);
    assign poly_drawn    = (state_q == StDone);
    assign busy          = (state_q != StIdle);

    assign isp_inst = words_q[0];
    assign tsp_inst = words_q[1];
    assign tcw      = words_q[2];
    assign vert_a_x = words_q[3];
    assign vert_a_y = words_q[4];
    assign vert_a_z = words_q[5];
    assign vert_b_x = words_q[6];
    assign vert_b_y = words_q[7];
    assign vert_b_z = words_q[8];
    assign vert_c_x = words_q[9];
    assign vert_c_y = words_q[10];
    assign vert_c_z = words_q[11];

endmodule

// File: tb/tb_isp_param_fetch.sv
// Scoreboard bench for isp_param_fetch: expected reads, polygons and done pulses are queued at
// trigger time and popped by negedge monitors as the DUT produces them.
module tb_isp_param_fetch;

    logic        clock = 1'b0;
    logic        reset, render_poly, poly_ack;
    logic [23:0] poly_addr;
    logic [2:0]  skip;
    logic [31:0] PARAM_BASE;
    logic        isp_vram_rd;
    logic [23:0] isp_vram_addr;
    logic [31:0] isp_vram_din = 32'd0;
    logic [31:0] isp_inst, tsp_inst, tcw;
    logic [31:0] vert_a_x, vert_a_y, vert_a_z, vert_b_x, vert_b_y, vert_b_z;
    logic [31:0] vert_c_x, vert_c_y, vert_c_z;
    logic        poly_valid, poly_drawn, busy;

    isp_param_fetch dut (
        .clock(clock), .reset(reset), .render_poly(render_poly), .poly_addr(poly_addr),
        .skip(skip), .PARAM_BASE(PARAM_BASE), .isp_vram_rd(isp_vram_rd),
        .isp_vram_addr(isp_vram_addr), .isp_vram_din(isp_vram_din), .isp_inst(isp_inst),
        .tsp_inst(tsp_inst), .tcw(tcw), .vert_a_x(vert_a_x), .vert_a_y(vert_a_y),
        .vert_a_z(vert_a_z), .vert_b_x(vert_b_x), .vert_b_y(vert_b_y), .vert_b_z(vert_b_z),
        .vert_c_x(vert_c_x), .vert_c_y(vert_c_y), .vert_c_z(vert_c_z),
        .poly_valid(poly_valid), .poly_ack(poly_ack), .poly_drawn(poly_drawn), .busy(busy)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] vram(input logic [23:0] a);
        return {~a[7:0], a};
    endfunction

    // One-cycle read latency VRAM model.
    always @(posedge clock) if (isp_vram_rd) isp_vram_din <= vram(isp_vram_addr);

    int total = 0;
    int bad = 0;
    int drawn_seen = 0;
    int accepted = 0;

    typedef struct {int unsigned cyc; logic [23:0] addr;} rd_t;
    typedef struct {int unsigned cyc; logic [11:0][31:0] w;} poly_t;
    rd_t         rd_q[$];
    poly_t       poly_q[$];
    int unsigned drawn_q[$];

    logic [11:0][31:0] cur;
    assign cur = {vert_c_z, vert_c_y, vert_c_x, vert_b_z, vert_b_y, vert_b_x,
                  vert_a_z, vert_a_y, vert_a_x, tcw, tsp_inst, isp_inst};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event want none (cycle %0d)", name, cyc);
    endtask

    // Monitors.
    logic              pv_prev = 1'b0;
    logic [11:0][31:0] snap;
    always @(negedge clock) begin
        rd_t   r;
        poly_t p;
        int unsigned d;
        if (isp_vram_rd) begin
            if (rd_q.size() == 0) flag("unexpected_read");
            else begin
                r = rd_q.pop_front();
                check("read_addr", 64'(isp_vram_addr), 64'(r.addr));
                check("read_cycle", 64'(cyc), 64'(r.cyc));
            end
        end
        if (poly_valid && !pv_prev) begin
            snap = cur;
            if (poly_q.size() == 0) flag("unexpected_poly_valid");
            else begin
                p = poly_q.pop_front();
                check("poly_valid_cycle", 64'(cyc), 64'(p.cyc));
                for (int k = 0; k < 12; k++) check($sformatf("word%0d", k), 64'(cur[k]), 64'(p.w[k]));
            end
        end else if (poly_valid) begin
            check("valid_stable", 64'(cur == snap), 64'd1);
            check("valid_no_read", 64'(isp_vram_rd), 64'd0);
        end
        pv_prev = poly_valid;
        if (poly_drawn) begin
            drawn_seen++;
            check("drawn_valid_low", 64'(poly_valid), 64'd0);
            if (drawn_q.size() == 0) flag("unexpected_poly_drawn");
            else begin
                d = drawn_q.pop_front();
                check("drawn_cycle", 64'(cyc), 64'(d));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [11:0][23:0] gen_addrs(input logic [23:0] b, input logic [2:0] sk);
        logic [11:0][23:0] a;
        for (int i = 0; i < 3; i++) a[i] = b + 24'(4 * i);
        for (int v = 0; v < 3; v++)
            for (int c = 0; c < 3; c++)
                a[3 + 3 * v + c] = b + 24'(12 + 4 * (v * (3 + int'(sk)) + c));
        return a;
    endfunction

    task automatic trigger(input logic [31:0] pb, input logic [23:0] pa, input logic [2:0] sk,
                           input int n_reads, input logic [11:0][23:0] a, input bit auto_ack,
                           output int unsigned t);
        poly_t p;
        PARAM_BASE  = pb;
        poly_addr   = pa;
        skip        = sk;
        render_poly = 1'b1;
        t = cyc;
        for (int k = 0; k < n_reads; k++) rd_q.push_back('{t + 1 + k, a[k]});
        if (n_reads == 12) begin
            p.cyc = t + 14;
            for (int k = 0; k < 12; k++) p.w[k] = vram(a[k]);
            poly_q.push_back(p);
            accepted++;
            if (auto_ack) drawn_q.push_back(t + 15);
        end
        tick();
        render_poly = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) flag("idle_timeout");
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rd"}, 64'(isp_vram_rd), 64'd0);
        check({tag, "_addr"}, 64'(isp_vram_addr), 64'd0);
        check({tag, "_valid"}, 64'(poly_valid), 64'd0);
        check({tag, "_drawn"}, 64'(poly_drawn), 64'd0);
        check({tag, "_words_zero"}, 64'(cur == '0), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int unsigned t;
        int n;
        logic [11:0][23:0] tab;
        reset = 1'b1; render_poly = 1'b0; poly_ack = 1'b0;
        poly_addr = '0; skip = '0; PARAM_BASE = '0;
        repeat (3) tick();
        @(negedge clock);
        check_zero("reset");
        tick();
        reset = 1'b0;
        tick();

        // Basic fetch, ack on first VALID cycle, then back-to-back trigger at T+16.
        poly_ack = 1'b1;
        trigger(32'h0010_0000, 24'h40, 3'd0, 12, gen_addrs(24'h100040, 3'd0), 1'b1, t);
        while (cyc < t + 16) tick();
        tab = {24'h23C, 24'h238, 24'h234, 24'h228, 24'h224, 24'h220,
               24'h214, 24'h210, 24'h20C, 24'h208, 24'h204, 24'h200};
        trigger(32'h0000_0100, 24'h100, 3'd2, 12, tab, 1'b1, t);
        wait_idle();

        // 24-bit wrap; upper base bits ignored.
        trigger(32'hA5FF_FFF0, 24'h8, 3'd1, 12, gen_addrs(24'hFFFFF8, 3'd1), 1'b1, t);
        wait_idle();

        // Ack withheld for 20 cycles.
        poly_ack = 1'b0;
        trigger(32'h0000_1000, 24'h20, 3'd3, 12, gen_addrs(24'h001020, 3'd3), 1'b0, t);
        n = 0;
        while (!poly_valid && n < 40) begin
            tick();
            n++;
        end
        check("valid_seen", 64'(poly_valid), 64'd1);
        repeat (20) tick();
        poly_ack = 1'b1;
        drawn_q.push_back(cyc + 1);
        tick();
        poly_ack = 1'b0;
        tick();
        @(negedge clock);
        check("idle_after_done", 64'(busy), 64'd0);
        tick();

        // Reset mid-FETCH at T+6: reads for words 0..5 only, then everything clears.
        poly_ack = 1'b1;
        trigger(32'h0002_0000, 24'h300, 3'd0, 6, gen_addrs(24'h020300, 3'd0), 1'b0, t);
        while (cyc < t + 6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_zero("midreset");
        repeat (5) tick();

        // Max skip: stride 10 words, still 12 reads.
        trigger(32'h0003_0000, 24'h10, 3'd7, 12, gen_addrs(24'h030010, 3'd7), 1'b1, t);
        wait_idle();

        // Reset and render_poly together: stays idle.
        reset = 1'b1;
        render_poly = 1'b1;
        tick();
        reset = 1'b0;
        render_poly = 1'b0;
        @(negedge clock);
        check("reset_wins", 64'(busy), 64'd0);
        repeat (3) tick();

        // render_poly while in FETCH and in DONE is ignored.
        trigger(32'h0004_0000, 24'h44, 3'd1, 12, gen_addrs(24'h040044, 3'd1), 1'b1, t);
        while (cyc < t + 5) tick();
        render_poly = 1'b1;
        tick();
        render_poly = 1'b0;
        while (cyc < t + 15) tick();
        render_poly = 1'b1;
        tick();
        render_poly = 1'b0;
        repeat (6) tick();
        @(negedge clock);
        check("ignored_trigger_idle", 64'(busy), 64'd0);

        repeat (3) tick();
        check("reads_pending", 64'(rd_q.size()), 64'd0);
        check("polys_pending", 64'(poly_q.size()), 64'd0);
        check("drawn_pending", 64'(drawn_q.size()), 64'd0);
        check("drawn_count", 64'(drawn_seen), 64'(accepted));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/isp_param_fetch.md
ISP_PARAM_FETCH -- requirements
Module: isp_param_fetch

Interface
REQ-001 SHALL have ports (clock, reset first):
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- render_poly  in  1  one-cycle start pulse from region-array/object-list parser
- poly_addr  in  24  byte offset of polygon parameters, from parser
- skip  in  3  extra 32-bit words per vertex after X/Y/Z
- PARAM_BASE  in  32  parameter-buffer base; bits [23:0] used
- isp_vram_rd  out  1  VRAM read strobe
- isp_vram_addr  out  24  VRAM byte address
- isp_vram_din  in  32  VRAM read data
- isp_inst, tsp_inst, tcw  out  32 each  polygon header words
- vert_a_x/y/z, vert_b_x/y/z, vert_c_x/y/z  out  32 each  vertex words
- poly_valid  out  1  all twelve output words valid
- poly_ack  in  1  downstream rasteriser consumed the polygon
- poly_drawn  out  1  one-cycle done pulse back to parser
- busy  out  1  high whenever not IDLE

Function
REQ-002 SHALL implement states IDLE, FETCH, LAST, VALID, DONE.
REQ-003 IDLE: render_poly=1 at cycle T -> latch base address B = (PARAM_BASE[23:0] + poly_addr) mod 2^24 and stride S = 3 + skip, then go to FETCH; render_poly outside IDLE SHALL be ignored.
REQ-004 VRAM read timing: data on isp_vram_din SHALL be valid exactly one cycle after the cycle isp_vram_rd is high; one read issued per cycle, no stalls.
REQ-005 FETCH SHALL issue 12 reads on cycles T+1..T+12, in word order 0..11, at byte addresses: words 0-2 at B, B+4, B+8; vertex v (0..2), component c (0..2) at B + 12 + 4*(v*S + c).
REQ-006 Address arithmetic SHALL be 24-bit, wrapping modulo 2^24; no carry out.
REQ-007 Skip words SHALL NOT be read and SHALL NOT add cycles; skip=7 gives stride 10 words.
REQ-008 Read word k SHALL be captured into its output register on cycle T+2+k: 0->isp_inst, 1->tsp_inst, 2->tcw, 3..5->vert_a x/y/z, 6..8->vert_b, 9..11->vert_c.
REQ-009 LAST is the single cycle (T+13) capturing word 11 with isp_vram_rd low; then VALID.
REQ-010 poly_valid SHALL be high from cycle T+14 while in VALID; output words SHALL be stable while poly_valid=1.
REQ-011 VALID: poly_ack=1 -> DONE next cycle; poly_ack outside VALID SHALL be ignored; poly_ack in the first VALID cycle is accepted.
REQ-012 DONE SHALL last one cycle with poly_drawn=1 and poly_valid=0, then return to IDLE; a render_poly in DONE is ignored.
REQ-013 isp_vram_rd SHALL be low in IDLE, LAST, VALID and DONE; isp_vram_addr holds its last value when not reading.
REQ-014 busy SHALL equal (state != IDLE).
REQ-015 Minimum trigger-to-trigger period SHALL be 16 cycles (ack on first VALID cycle).

Reset
REQ-016 reset=1 at any clock edge, including mid-FETCH or in VALID, SHALL force IDLE and clear isp_vram_rd, isp_vram_addr, all twelve data outputs, poly_valid, poly_drawn and busy to 0 the next cycle.
REQ-017 After reset, no read SHALL be issued until a new render_poly pulse; an in-flight read's returning data SHALL be discarded.
REQ-018 reset and render_poly asserted together: reset wins, stays IDLE.

Verification
REQ-019 PARAM_BASE=0x100000, poly_addr=0x40, skip=0 -> reads at 0x100040..0x10006C step 4 on T+1..T+12; poly_valid at T+14; outputs match memory.
REQ-020 skip=2, base B=0x000200 -> vertex reads at 0x20C,0x210,0x214, 0x220,0x224,0x228, 0x234,0x238,0x23C.
REQ-021 PARAM_BASE=0xFFFFF0, poly_addr=0x8 -> addresses wrap: 0xFFFFF8, 0xFFFFFC, 0x000000, ...
REQ-022 poly_ack withheld 20 cycles -> poly_valid held, outputs stable, no reads; ack -> poly_drawn single pulse next cycle, then IDLE.
REQ-023 reset at T+6 -> next cycle all outputs 0, no reads; later trigger completes normally.
REQ-024 render_poly pulses while busy -> ignored; exactly one poly_drawn per accepted trigger.
